// File: rtl/cpu_pkg.sv
// Shared fetch-side types: reset PC, fetch FSM states and control-transfer target selection.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } fetch_state_e;

  typedef enum logic [1:0] {
    TSEL_NONE,
    TSEL_BR,
    TSEL_JAL,
    TSEL_JR
  } tgt_sel_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational control-transfer decode for the D-stage instruction: redirect event and target PC.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              d_valid_i,
  input  logic              stall_i,
  input  logic [ADDR_W-1:0] d_pc_i,
  input  logic              is_branch_i,
  input  logic              branch_taken_i,
  input  logic              is_jal_i,
  input  logic              is_jr_i,
  input  logic [15:0]       imm16_i,
  input  logic [25:0]       instr_index_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic [ADDR_W-1:0] target_o,
  output logic              ev_o
);

  logic [ADDR_W-1:0]        pc4;
  logic signed [ADDR_W-1:0] br_off;
  tgt_sel_e                 sel;

  always_comb begin
    pc4    = d_pc_i + ADDR_W'(4);
    br_off = $signed({{(ADDR_W-18){imm16_i[15]}}, imm16_i, 2'b00});

    // jr outranks jal, which outranks a taken branch
    sel = TSEL_NONE;
    if (is_jr_i)                           sel = TSEL_JR;
    else if (is_jal_i)                     sel = TSEL_JAL;
    else if (is_branch_i && branch_taken_i) sel = TSEL_BR;

    case (sel)
      TSEL_JR:  target_o = jr_target_i;
      TSEL_JAL: target_o = {pc4[ADDR_W-1:28], instr_index_i, 2'b00};
      TSEL_BR:  target_o = pc4 + $unsigned(br_off);
      default:  target_o = pc4;
    endcase

    ev_o = d_valid_i && !stall_i && (sel != TSEL_NONE);
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// F-stage PC sequencer: imem request handshake, delay-slot redirects and a one-entry stall skid buffer.
// Optional performance counters are built when FETCH_PC_CTRL_PERF_EN is defined.
module fetch_pc_ctrl
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              d_valid_i,
  input  logic [ADDR_W-1:0] d_pc_i,
  input  logic              is_branch_i,
  input  logic              branch_taken_i,
  input  logic              is_jal_i,
  input  logic              is_jr_i,
  input  logic [15:0]       imm16_i,
  input  logic [25:0]       instr_index_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic              fetch_req_o,
  output logic [ADDR_W-1:0] fetch_addr_o,
  input  logic              fetch_ack_i,
  input  logic [31:0]       fetch_data_i,
  output logic [31:0]       instr_o,
  output logic              instr_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              redirect_o
`ifdef FETCH_PC_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_redirect_cnt_o,
  output logic [31:0]       perf_wait_cnt_o
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [31:0]       buf_q, buf_d;
  logic              redirect_q, redirect_d;
  logic [ADDR_W-1:0] target;
  logic              ev;
  logic              cons;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc_calc (
    .d_valid_i      (d_valid_i),
    .stall_i        (stall_i),
    .d_pc_i         (d_pc_i),
    .is_branch_i    (is_branch_i),
    .branch_taken_i (branch_taken_i),
    .is_jal_i       (is_jal_i),
    .is_jr_i        (is_jr_i),
    .imm16_i        (imm16_i),
    .instr_index_i  (instr_index_i),
    .jr_target_i    (jr_target_i),
    .target_o       (target),
    .ev_o           (ev)
  );

  always_comb begin
    fetch_req_o   = 1'b0;
    instr_o       = '0;
    instr_valid_o = 1'b0;
    state_d       = state_q;
    buf_d         = buf_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        fetch_req_o   = 1'b1;
        instr_o       = fetch_data_i;
        instr_valid_o = fetch_ack_i;
        // a word returned under stall is parked so imem is never asked twice
        if (fetch_ack_i && stall_i) begin
          buf_d   = fetch_data_i;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instr_o       = buf_q;
        instr_valid_o = 1'b1;
        if (!stall_i) state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase

    cons       = instr_valid_o && !stall_i;
    redirect_d = ev;

    // the word consumed alongside a redirect is the delay slot; otherwise the target waits in pend
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (cons) begin
      pend_d = 1'b0;
      if (ev)          pc_d = target;
      else if (pend_q) pc_d = pend_tgt_q;
      else             pc_d = pc_q + ADDR_W'(4);
    end else if (ev) begin
      pend_d     = 1'b1;
      pend_tgt_d = target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      buf_q      <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      buf_q      <= buf_d;
      redirect_q <= redirect_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_tgt_q <= pend_tgt_d;
  end

  assign fetch_addr_o = pc_q;
  assign pc_o         = pc_q;
  assign redirect_o   = redirect_q;

  // a control transfer sitting in a delay slot is illegal in this ISA
  a_no_ev_in_delay_slot: assert property (@(posedge clk) disable iff (!reset_n) !(ev && pend_q));

`ifdef FETCH_PC_CTRL_PERF_EN
  logic [31:0] perf_redirect_cnt_q, perf_redirect_cnt_d;
  logic [31:0] perf_wait_cnt_q, perf_wait_cnt_d;

  always_comb begin
    perf_redirect_cnt_d = perf_redirect_cnt_q + {31'd0, ev};
    perf_wait_cnt_d     = perf_wait_cnt_q + {31'd0, fetch_req_o && !fetch_ack_i};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_redirect_cnt_q <= '0;
      perf_wait_cnt_q     <= '0;
    end else begin
      perf_redirect_cnt_q <= perf_redirect_cnt_d;
      perf_wait_cnt_q     <= perf_wait_cnt_d;
    end
  end

  assign perf_redirect_cnt_o = perf_redirect_cnt_q;
  assign perf_wait_cnt_o     = perf_wait_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: a reference model checked every cycle plus hand-computed fetch addresses.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        d_valid_i = 1'b0;
  logic [31:0] d_pc_i = '0;
  logic        is_branch_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic        is_jal_i = 1'b0;
  logic        is_jr_i = 1'b0;
  logic [15:0] imm16_i = '0;
  logic [25:0] instr_index_i = '0;
  logic [31:0] jr_target_i = '0;
  logic        fetch_ack_i = 1'b0;
  logic [31:0] fetch_data_i;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic        redirect_o;
`ifdef FETCH_PC_CTRL_PERF_EN
  logic [31:0] perf_redirect_cnt_o;
  logic [31:0] perf_wait_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] cons_log[$];

  always #5 clk = ~clk;

  // imem contents: every word is a distinct function of its address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign fetch_data_i = mem(fetch_addr_o);

  fetch_pc_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall_i        (stall_i),
    .d_valid_i      (d_valid_i),
    .d_pc_i         (d_pc_i),
    .is_branch_i    (is_branch_i),
    .branch_taken_i (branch_taken_i),
    .is_jal_i       (is_jal_i),
    .is_jr_i        (is_jr_i),
    .imm16_i        (imm16_i),
    .instr_index_i  (instr_index_i),
    .jr_target_i    (jr_target_i),
    .fetch_req_o    (fetch_req_o),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_ack_i    (fetch_ack_i),
    .fetch_data_i   (fetch_data_i),
    .instr_o        (instr_o),
    .instr_valid_o  (instr_valid_o),
    .pc_o           (pc_o),
    .redirect_o     (redirect_o)
`ifdef FETCH_PC_CTRL_PERF_EN
    ,
    .perf_redirect_cnt_o (perf_redirect_cnt_o),
    .perf_wait_cnt_o     (perf_wait_cnt_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_booting = 1'b1;
  logic        m_holding = 1'b0;
  logic [31:0] m_held_word = '0;
  logic [31:0] m_pc = 32'h0000_3000;
  logic        m_pending = 1'b0;
  logic [31:0] m_pending_tgt = '0;
  logic        m_redirect = 1'b0;
  logic        m_ev, m_take;
  logic [31:0] m_tgt, m_seq;

  function automatic logic exp_valid();
    if (m_booting) return 1'b0;
    if (m_holding) return 1'b1;
    return fetch_ack_i;
  endfunction

  function automatic logic [31:0] exp_instr();
    if (m_booting) return 32'h0;
    if (m_holding) return m_held_word;
    return mem(m_pc);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_booting  = 1'b1;
      m_holding  = 1'b0;
      m_held_word = '0;
      m_pc       = 32'h0000_3000;
      m_pending  = 1'b0;
      m_redirect = 1'b0;
    end else begin
      m_take = exp_valid() && !stall_i;
      m_ev   = d_valid_i && !stall_i && (is_jr_i || is_jal_i || (is_branch_i && branch_taken_i));
      m_seq  = d_pc_i + 32'd4;
      if (is_jr_i)       m_tgt = jr_target_i;
      else if (is_jal_i) m_tgt = {m_seq[31:28], 28'(instr_index_i) * 28'd4};
      else               m_tgt = m_seq + 32'($signed(imm16_i)) * 32'd4;
      m_redirect = m_ev;

      if (m_booting) m_booting = 1'b0;
      else if (m_holding) begin
        if (!stall_i) m_holding = 1'b0;
      end else if (fetch_ack_i && stall_i) begin
        m_holding   = 1'b1;
        m_held_word = mem(m_pc);
      end

      if (m_take) begin
        m_pc      = m_ev ? m_tgt : (m_pending ? m_pending_tgt : m_pc + 32'd4);
        m_pending = 1'b0;
      end else if (m_ev) begin
        m_pending     = 1'b1;
        m_pending_tgt = m_tgt;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("model_req",      {31'd0, fetch_req_o},   {31'd0, !m_booting && !m_holding});
    chk("model_addr",     fetch_addr_o,           m_pc);
    chk("model_pc",       pc_o,                   m_pc);
    chk("model_valid",    {31'd0, instr_valid_o}, {31'd0, exp_valid()});
    chk("model_instr",    instr_o,                exp_instr());
    chk("model_redirect", {31'd0, redirect_o},    {31'd0, m_redirect});
    if (reset_n && instr_valid_o && !stall_i) cons_log.push_back(pc_o);
  end

  // ---------------- directed stimulus ----------------
  task automatic nextcyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clrd();
    d_valid_i = 1'b0; is_branch_i = 1'b0; branch_taken_i = 1'b0;
    is_jal_i = 1'b0; is_jr_i = 1'b0;
  endtask

  task automatic set_br(input logic [31:0] pc, input logic [15:0] imm, input logic taken);
    clrd();
    d_valid_i = 1'b1; is_branch_i = 1'b1; branch_taken_i = taken;
    d_pc_i = pc; imm16_i = imm;
  endtask

  function automatic int count_cons(input logic [31:0] a);
    int n = 0;
    foreach (cons_log[i]) if (cons_log[i] == a) n++;
    return n;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",      {31'd0, fetch_req_o},   32'd0);
    chk("rst_valid",    {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr",    instr_o,                32'd0);
    chk("rst_redirect", {31'd0, redirect_o},    32'd0);
    chk("rst_pc",       pc_o,                   32'h0000_3000);

    nextcyc(); reset_n = 1'b1; fetch_ack_i = 1'b1;
    @(negedge clk); chk("boot_req", {31'd0, fetch_req_o}, 32'd0);
    nextcyc(); @(negedge clk); chk("seq_addr0", fetch_addr_o, 32'h3000);
    chk("seq_valid0", {31'd0, instr_valid_o}, 32'd1);
    nextcyc(); @(negedge clk); chk("seq_addr1", fetch_addr_o, 32'h3004);
    nextcyc(); @(negedge clk); chk("seq_addr2", fetch_addr_o, 32'h3008);
    chk("seq_valid2", {31'd0, instr_valid_o}, 32'd1);

    // reset in the middle of an outstanding request
    nextcyc(); fetch_ack_i = 1'b0;
    @(negedge clk); chk("wait_req", {31'd0, fetch_req_o}, 32'd1);
    nextcyc(); #2; reset_n = 1'b0; #1;
    chk("rst_mid_req", {31'd0, fetch_req_o}, 32'd0);
    nextcyc(); nextcyc(); reset_n = 1'b1; fetch_ack_i = 1'b1;
    nextcyc(); @(negedge clk); chk("rerst_addr", fetch_addr_o, 32'h3000);
    chk("rerst_req", {31'd0, fetch_req_o}, 32'd1);

    // taken beq at 0x3000, delay slot 0x3004 consumed together
    nextcyc(); set_br(32'h3000, 16'h0004, 1'b1);
    @(negedge clk); chk("beq_slot_addr", fetch_addr_o, 32'h3004);
    chk("beq_redir_pre", {31'd0, redirect_o}, 32'd0);

    // jal at 0x3010 while the delay slot ack is late
    nextcyc(); clrd(); d_valid_i = 1'b1; is_jal_i = 1'b1; d_pc_i = 32'h3010;
    instr_index_i = 26'h0000C10; fetch_ack_i = 1'b0;
    @(negedge clk); chk("beq_tgt_addr", fetch_addr_o, 32'h3014);
    chk("beq_redir", {31'd0, redirect_o}, 32'd1);
    nextcyc(); clrd();
    @(negedge clk); chk("jal_wait_addr", fetch_addr_o, 32'h3014);
    chk("jal_redir", {31'd0, redirect_o}, 32'd1);
    nextcyc();
    @(negedge clk); chk("jal_wait_addr2", fetch_addr_o, 32'h3014);
    chk("jal_redir_off", {31'd0, redirect_o}, 32'd0);
    nextcyc(); fetch_ack_i = 1'b1;
    @(negedge clk); chk("jal_slot_valid", {31'd0, instr_valid_o}, 32'd1);

    // ack under stall parks the word
    nextcyc(); stall_i = 1'b1;
    @(negedge clk); chk("jal_tgt_addr", fetch_addr_o, 32'h3040);
    nextcyc(); fetch_ack_i = 1'b0;
    @(negedge clk); chk("hold_req", {31'd0, fetch_req_o}, 32'd0);
    chk("hold_instr", instr_o, mem(32'h3040));
    nextcyc();
    @(negedge clk); chk("hold_instr2", instr_o, mem(32'h3040));
    nextcyc(); stall_i = 1'b0;
    @(negedge clk); chk("hold_release_valid", {31'd0, instr_valid_o}, 32'd1);
    nextcyc(); fetch_ack_i = 1'b1;
    @(negedge clk); chk("after_hold_addr", fetch_addr_o, 32'h3044);
    chk("after_hold_req", {31'd0, fetch_req_o}, 32'd1);

    // jr and jal flagged together: jr wins
    nextcyc(); clrd(); d_valid_i = 1'b1; is_jr_i = 1'b1; is_jal_i = 1'b1;
    d_pc_i = 32'h3044; jr_target_i = 32'h0000_4000; instr_index_i = 26'h0000C10;
    @(negedge clk); chk("jr_slot_addr", fetch_addr_o, 32'h3048);
    nextcyc(); clrd();
    @(negedge clk); chk("jr_tgt_addr", fetch_addr_o, 32'h4000);

    // backward branch, then jr near the top of the address space
    nextcyc(); set_br(32'h4000, 16'hFFFE, 1'b1);
    @(negedge clk); chk("bwd_slot_addr", fetch_addr_o, 32'h4004);
    nextcyc(); clrd(); d_valid_i = 1'b1; is_jr_i = 1'b1; jr_target_i = 32'hFFFF_FFF8;
    @(negedge clk); chk("bwd_tgt_addr", fetch_addr_o, 32'h3FFC);
    nextcyc(); clrd();
    @(negedge clk); chk("hi_addr0", fetch_addr_o, 32'hFFFF_FFF8);
    nextcyc(); set_br(32'hFFFF_FFF8, 16'h0010, 1'b0);
    @(negedge clk); chk("hi_addr1", fetch_addr_o, 32'hFFFF_FFFC);
    nextcyc(); set_br(32'hFFFF_FFF0, 16'h0010, 1'b1);
    @(negedge clk); chk("pc_wrap_addr", fetch_addr_o, 32'h0000_0000);
    chk("not_taken_redir", {31'd0, redirect_o}, 32'd0);
    nextcyc(); clrd();
    @(negedge clk); chk("br_wrap_addr", fetch_addr_o, 32'h0000_0034);

    chk("cons_3040_once", 32'(count_cons(32'h3040)), 32'd1);
    chk("cons_3044_once", 32'(count_cons(32'h3044)), 32'd1);
    chk("cons_3014_once", 32'(count_cons(32'h3014)), 32'd1);

    nextcyc(); nextcyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
